text_term_writer: RTL and testbench

- Terminal-style write controller for the character buffer that the VGA text display reads.
- Accepts a byte stream through a valid/ready handshake and maintains the cursor.
- Interprets control codes and writes glyph codes into the buffer's write port.
- Issues a one-cycle scroll pulse to the display controller at the bottom row and blanks the newly exposed line. It mirrors the display's top-line pointer so the two stay aligned.

---
 rtl/text_term_writer.sv | 206 ++++++++++++++++++++
 tb/tb_text_term_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_term_writer.sv
// Terminal-style writer for the VGA text buffer: decodes a byte stream, keeps the
// cursor, writes glyphs, scrolls at the bottom row and blanks newly exposed lines.
module text_term_writer #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int H_CHARS = H_DISP / 8,
    localparam int V_CHARS = V_DISP / 8,
    localparam int MAX_CHARS = H_CHARS * V_CHARS,
    localparam int AW = $clog2(MAX_CHARS),
    localparam int CW = $clog2(H_CHARS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_char_i,
    output logic          in_ready_o,
    output logic          we_o,
    output logic [AW-1:0] addr_write_o,
    output logic [7:0]    data_write_o,
    output logic          scroll_o,
    output logic [AW-1:0] cursor_addr_o
);
    // state | meaning
    // IDLE     | waiting for a byte, in_ready high
    // WRITE    | single glyph write in flight
    // SCROLL   | one-cycle scroll pulse to the display
    // CLR_LINE | blanking the newly exposed line
    // CLR_ALL  | blanking the whole buffer
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] SCROLL   = 3'd2;
    localparam logic [2:0] CLR_LINE = 3'd3;
    localparam logic [2:0] CLR_ALL  = 3'd4;

    localparam int RW = (V_CHARS > 1) ? $clog2(V_CHARS) : 1;
    localparam logic [AW-1:0] H_STEP    = AW'(H_CHARS);
    localparam logic [AW-1:0] LAST_LINE = AW'(MAX_CHARS - H_CHARS);
    localparam logic [AW:0]   LINE_CNT  = (AW + 1)'(H_CHARS);
    localparam logic [AW:0]   ALL_CNT   = (AW + 1)'(MAX_CHARS);
    localparam logic [2:0]    RST_STATE = CLEAR_ON_RESET ? CLR_ALL : IDLE;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] line_q, line_d;
    logic [AW-1:0] top_q, top_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          nl_q, nl_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          scroll_q, scroll_d;
    logic          ready_q, ready_d;
    logic [AW-1:0] cursor_q, cursor_d;
    logic          accept;
    logic          do_nl;

    function automatic logic [AW-1:0] line_adv(input logic [AW-1:0] a);
        if (a >= LAST_LINE) return '0;
        return a + H_STEP;
    endfunction

    assign accept = in_valid_i && ready_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        line_d   = line_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        nl_d     = nl_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        scroll_d = 1'b0;
        do_nl    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_char_i >= 8'h20 && in_char_i <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = line_q + AW'(col_q);
                        data_d  = in_char_i;
                        state_d = WRITE;
                        nl_d    = (col_q == CW'(H_CHARS - 1));
                        if (col_q < CW'(H_CHARS - 1)) col_d = col_q + CW'(1);
                    end else begin
                        case (in_char_i)
                            8'h0A: do_nl = 1'b1;
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - CW'(1);
                                    we_d    = 1'b1;
                                    addr_d  = line_q + AW'(col_q - CW'(1));
                                    data_d  = 8'h20;
                                    nl_d    = 1'b0;
                                    state_d = WRITE;
                                end
                            end
                            8'h0C: begin
                                cnt_d   = '0;
                                state_d = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (nl_q) do_nl = 1'b1;
                else      state_d = IDLE;
            end
            SCROLL: begin
                cnt_d   = '0;
                state_d = CLR_LINE;
            end
            CLR_LINE: begin
                if (cnt_q < LINE_CNT) begin
                    we_d   = 1'b1;
                    addr_d = line_q + cnt_q[AW-1:0];
                    data_d = 8'h20;
                    cnt_d  = cnt_q + (AW + 1)'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            CLR_ALL: begin
                if (cnt_q < ALL_CNT) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[AW-1:0];
                    data_d = 8'h20;
                    cnt_d  = cnt_q + (AW + 1)'(1);
                end else begin
                    // display top pointer is not ours to reset, so the cursor follows it
                    row_d   = '0;
                    col_d   = '0;
                    line_d  = top_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_nl) begin
            col_d = '0;
            nl_d  = 1'b0;
            if (row_q < RW'(V_CHARS - 1)) begin
                row_d   = row_q + RW'(1);
                line_d  = line_adv(line_q);
                state_d = IDLE;
            end else begin
                top_d    = line_adv(top_q);
                line_d   = line_adv(line_q);
                scroll_d = 1'b1;
                state_d  = SCROLL;
            end
        end

        ready_d  = (state_d == IDLE);
        cursor_d = line_d + AW'(col_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RST_STATE;
            col_q    <= '0;
            row_q    <= '0;
            line_q   <= '0;
            top_q    <= '0;
            cnt_q    <= '0;
            nl_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            scroll_q <= 1'b0;
            ready_q  <= 1'b0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            line_q   <= line_d;
            top_q    <= top_d;
            cnt_q    <= cnt_d;
            nl_q     <= nl_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            scroll_q <= scroll_d;
            ready_q  <= ready_d;
            cursor_q <= cursor_d;
        end
    end

    assign in_ready_o    = ready_q;
    assign we_o          = we_q;
    assign addr_write_o  = addr_q;
    assign data_write_o  = data_q;
    assign scroll_o      = scroll_q;
    assign cursor_addr_o = cursor_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Bench for text_term_writer on a 8x4 character screen: directed table, hand-written
// reset/hold sequences and random bytes checked against a screen-level model.
module tb_text_term_writer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int MAXC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready_o, we_o, scroll_o;
    logic [4:0] addr_write_o, cursor_addr_o;
    logic [7:0] data_write_o;

    text_term_writer #(.H_DISP(64), .V_DISP(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_char_i(in_char),
        .in_ready_o(in_ready_o), .we_o(we_o), .addr_write_o(addr_write_o),
        .data_write_o(data_write_o), .scroll_o(scroll_o), .cursor_addr_o(cursor_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int d; } wr_t;
    typedef struct { logic [7:0] ch; int cur; int nw; int a0; logic [7:0] d; int scr; } vec_t;

    wr_t act_q[$];
    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  scr_cnt = 0;
    int  s0 = 0;
    int  m_col, m_row, m_line, m_top, m_scr;

    always @(negedge clk) begin
        if (we_o) begin
            wr_t w;
            w.a = int'(addr_write_o);
            w.d = int'(data_write_o);
            act_q.push_back(w);
            n_vec++;
            if (in_ready_o) begin
                n_bad++;
                $display("FAIL we_while_ready: ready=%0b with we=1, want ready=0", in_ready_o);
            end
        end
        if (scroll_o) begin
            scr_cnt++;
            n_vec++;
            if (we_o) begin
                n_bad++;
                $display("FAIL scroll_with_we: we=%0b during scroll, want 0", we_o);
            end
        end
    end

    task automatic chk(string nm, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic send(logic [7:0] ch, output logic first_we);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = ch;
        while (!in_ready_o && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready_o) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        first_we = we_o;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (!in_ready_o && g < 500);
        if (!in_ready_o) chk("idle_timeout", 0, 1);
    endtask

    task automatic compare(string nm, int exp_cur, int exp_scr);
        chk({nm, "_cursor"}, int'(cursor_addr_o), exp_cur);
        chk({nm, "_scrolls"}, scr_cnt - s0, exp_scr);
        chk({nm, "_nwrites"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), act_q[i].a, exp_q[i].a);
            chk($sformatf("%s_data%0d", nm, i), act_q[i].d, exp_q[i].d);
        end
    endtask

    task automatic run_vec(string nm, vec_t v);
        logic fw;
        exp_q.delete();
        for (int i = 0; i < v.nw; i++) exp_q.push_back('{v.a0 + i, int'(v.d)});
        act_q.delete();
        s0 = scr_cnt;
        send(v.ch, fw);
        wait_idle();
        compare(nm, v.cur, v.scr);
        if (v.nw == 1) chk({nm, "_we_next_cycle"}, int'(fw), 1);
    endtask

    function automatic int adv(int a);
        return (a >= MAXC - H) ? 0 : a + H;
    endfunction

    function automatic void m_push(int a, int d);
        exp_q.push_back('{a, d});
    endfunction

    function automatic void m_newline();
        m_col = 0;
        if (m_row < V - 1) begin
            m_row++;
            m_line = adv(m_line);
        end else begin
            m_scr++;
            m_top  = adv(m_top);
            m_line = adv(m_line);
            for (int i = 0; i < H; i++) m_push(m_line + i, 8'h20);
        end
    endfunction

    function automatic void m_byte(logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            m_push(m_line + m_col, int'(ch));
            if (m_col < H - 1) m_col++;
            else m_newline();
        end else if (ch == 8'h0A) m_newline();
        else if (ch == 8'h0D) m_col = 0;
        else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_push(m_line + m_col, 8'h20);
            end
        end else if (ch == 8'h0C) begin
            for (int i = 0; i < MAXC; i++) m_push(i, 8'h20);
            m_row = 0;
            m_col = 0;
            m_line = m_top;
        end
    endfunction

    task automatic expect_full_clear(string nm);
        exp_q.delete();
        for (int i = 0; i < MAXC; i++) exp_q.push_back('{i, 8'h20});
        compare(nm, 0, 0);
    endtask

    vec_t tbl[23];

    initial begin
        logic fw;
        int g;
        logic [7:0] ch;
        int r;

        tbl[0] = '{8'h41, 1, 1, 0, 8'h41, 0};
        tbl[1] = '{8'h0D, 0, 0, 0, 8'h00, 0};
        for (int k = 0; k < 8; k++) tbl[2 + k] = '{8'h41, (k == 7) ? 8 : k + 1, 1, k, 8'h41, 0};
        tbl[10] = '{8'h0A, 16, 0, 0, 8'h00, 0};
        tbl[11] = '{8'h0A, 24, 0, 0, 8'h00, 0};
        tbl[12] = '{8'h0A, 0, 8, 0, 8'h20, 1};
        tbl[13] = '{8'h0A, 8, 8, 8, 8'h20, 1};
        tbl[14] = '{8'h08, 8, 0, 0, 8'h00, 0};
        tbl[15] = '{8'h61, 9, 1, 8, 8'h61, 0};
        tbl[16] = '{8'h62, 10, 1, 9, 8'h62, 0};
        tbl[17] = '{8'h63, 11, 1, 10, 8'h63, 0};
        tbl[18] = '{8'h08, 10, 1, 10, 8'h20, 0};
        tbl[19] = '{8'h0D, 8, 0, 0, 8'h00, 0};
        tbl[20] = '{8'h07, 8, 0, 0, 8'h00, 0};
        tbl[21] = '{8'h0C, 16, 32, 0, 8'h20, 0};
        tbl[22] = '{8'h5A, 17, 1, 16, 8'h5A, 0};

        // reset values, then the power-on clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(in_ready_o), 0);
        chk("rst_we", int'(we_o), 0);
        chk("rst_scroll", int'(scroll_o), 0);
        chk("rst_cursor", int'(cursor_addr_o), 0);
        chk("rst_addr", int'(addr_write_o), 0);
        chk("rst_data", int'(data_write_o), 0);
        @(negedge clk);
        act_q.delete();
        s0 = scr_cnt;
        rst = 1'b0;
        wait_idle();
        expect_full_clear("por_clear");

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // byte offered while in_ready is low is held and consumed once
        act_q.delete();
        s0 = scr_cnt;
        send(8'h50, fw);
        send(8'h51, fw);
        wait_idle();
        exp_q.delete();
        exp_q.push_back('{17, 8'h50});
        exp_q.push_back('{18, 8'h51});
        compare("hold", 19, 0);

        run_vec("lf_a", '{8'h0A, 24, 0, 0, 8'h00, 0});
        run_vec("lf_b", '{8'h0A, 0, 0, 0, 8'h00, 0});
        run_vec("lf_c", '{8'h0A, 8, 0, 0, 8'h00, 0});

        // reset in the middle of the line clear that follows a scroll
        s0 = scr_cnt;
        send(8'h0A, fw);
        g = 0;
        while (scr_cnt == s0 && g < 50) begin @(negedge clk); g++; end
        chk("mid_scroll_seen", scr_cnt - s0, 1);
        g = 0;
        while (!we_o && g < 50) begin @(negedge clk); g++; end
        chk("mid_clear_started", int'(we_o), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_we", int'(we_o), 0);
        chk("midrst_scroll", int'(scroll_o), 0);
        chk("midrst_cursor", int'(cursor_addr_o), 0);
        chk("midrst_ready", int'(in_ready_o), 0);
        @(negedge clk);
        rst = 1'b0;
        act_q.delete();
        s0 = scr_cnt;
        wait_idle();
        expect_full_clear("midrst_clear");

        // random bytes against the screen model
        m_col = 0; m_row = 0; m_line = 0; m_top = 0; m_scr = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 68)      ch = 8'($urandom_range(32, 126));
            else if (r < 80) ch = 8'h0A;
            else if (r < 85) ch = 8'h0D;
            else if (r < 93) ch = 8'h08;
            else if (r < 95) ch = 8'h0C;
            else             ch = 8'($urandom_range(127, 255));
            exp_q.delete();
            act_q.delete();
            m_scr = 0;
            m_byte(ch);
            s0 = scr_cnt;
            send(ch, fw);
            wait_idle();
            compare($sformatf("rnd%0d_%02h", n, ch), m_line + m_col, m_scr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
